// File: rtl/countdown_timer_bcd.sv
// MM:SS countdown timer with a BCD digit register set.
// Counts down one second per tick_en while running, flags expiry, and drives
// four BCD digits to the seven-segment driver.
module countdown_timer_bcd #(
    parameter int MAX_MIN  = 99,
    parameter int INIT_MIN = 2,
    parameter int INIT_SEC = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       load,
    input  logic [6:0] preset_min,
    input  logic [5:0] preset_sec,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [6:0] MAX_MIN_C = 7'(MAX_MIN);
    localparam logic [3:0] INIT_MT   = 4'(INIT_MIN / 10);
    localparam logic [3:0] INIT_MO   = 4'(INIT_MIN % 10);
    localparam logic [3:0] INIT_ST   = 4'(INIT_SEC / 10);
    localparam logic [3:0] INIT_SO   = 4'(INIT_SEC % 10);

    // Saturate the minutes preset at the largest displayable value.
    function automatic logic [6:0] clamp_min(input logic [6:0] v);
        return (v > MAX_MIN_C) ? MAX_MIN_C : v;
    endfunction

    // Saturate the seconds preset at 59.
    function automatic logic [6:0] clamp_sec(input logic [5:0] v);
        return (v > 6'd59) ? 7'd59 : {1'b0, v};
    endfunction

    // Binary 0..99 to two BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 7'd10);
        o = 4'(v - 7'(t) * 7'd10);
        return {t, o};
    endfunction

    state_t     state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       expired_q, expired_d;

    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
    logic       dec_zero;
    logic       cur_zero;
    logic [7:0] load_min_bcd, load_sec_bcd;

    // One-second BCD decrement with borrow chain; only used when value != 00:00.
    always_comb begin
        dec_mt = min_tens_q;
        dec_mo = min_ones_q;
        dec_st = sec_tens_q;
        dec_so = sec_ones_q;
        if (sec_ones_q != 4'd0) begin
            dec_so = sec_ones_q - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (sec_tens_q != 4'd0) begin
                dec_st = sec_tens_q - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (min_ones_q != 4'd0) begin
                    dec_mo = min_ones_q - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = min_tens_q - 4'd1;
                end
            end
        end
        dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
                   (dec_st == 4'd0) && (dec_so == 4'd0);
        cur_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                   (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
        load_min_bcd = to_bcd(clamp_min(preset_min));
        load_sec_bcd = to_bcd(clamp_sec(preset_sec));
    end

    // Next-state and next-output logic; priority load > pause > start > tick_en.
    always_comb begin
        state_d    = state_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;

        if (load) begin
            state_d    = IDLE;
            min_tens_d = load_min_bcd[7:4];
            min_ones_d = load_min_bcd[3:0];
            sec_tens_d = load_sec_bcd[7:4];
            sec_ones_d = load_sec_bcd[3:0];
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pause && start && !cur_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick_en && !cur_zero) begin
                        min_tens_d = dec_mt;
                        min_ones_d = dec_mo;
                        sec_tens_d = dec_st;
                        sec_ones_d = dec_so;
                        if (dec_zero) begin
                            state_d = DONE;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause && start) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d    = DONE;
                    min_tens_d = 4'd0;
                    min_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    sec_ones_d = 4'd0;
                end
                default: state_d = IDLE;
            endcase
        end

        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
        expired_d = (state_d == DONE) && (state_q != DONE);
    end

    // State, digit and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            min_tens_q <= INIT_MT;
            min_ones_q <= INIT_MO;
            sec_tens_q <= INIT_ST;
            sec_ones_q <= INIT_SO;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            running_q  <= running_d;
            done_q     <= done_d;
            expired_q  <= expired_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign running  = running_q;
    assign done     = done_q;
    assign expired  = expired_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd: a vector table of single-cycle
// stimulus with expected outputs, plus a full 1:05 countdown sequence.
module tb_countdown_timer_bcd;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_en;
    logic       load;
    logic [6:0] preset_min;
    logic [5:0] preset_sec;
    logic       start;
    logic       pause;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done, expired;

    int checks = 0;
    int errors = 0;

    countdown_timer_bcd #(.MAX_MIN(99), .INIT_MIN(2), .INIT_SEC(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .load       (load),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
        .start      (start),
        .pause      (pause),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .done       (done),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       ld;
        logic [6:0] pm;
        logic [5:0] ps;
        logic       st;
        logic       pa;
        logic       tk;
        logic [15:0] dig;
        logic       run;
        logic       dn;
        logic       ex;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic r, input logic l,
                       input logic [6:0] pm, input logic [5:0] ps,
                       input logic s, input logic p, input logic t,
                       input logic [15:0] d, input logic ru, input logic dn,
                       input logic ex);
        vec_t v;
        v.name = nm; v.rst = r; v.ld = l; v.pm = pm; v.ps = ps;
        v.st = s; v.pa = p; v.tk = t; v.dig = d; v.run = ru; v.dn = dn; v.ex = ex;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic l, input logic [6:0] pm,
                         input logic [5:0] ps, input logic s, input logic p,
                         input logic t);
        reset = r; load = l; preset_min = pm; preset_sec = ps;
        start = s; pause = p; tick_en = t;
    endtask

    task automatic check(input string nm, input logic [15:0] d,
                         input logic ru, input logic dn, input logic ex);
        logic [15:0] got;
        got = {min_tens, min_ones, sec_tens, sec_ones};
        checks++;
        if (got !== d || running !== ru || done !== dn || expired !== ex) begin
            errors++;
            $display("FAIL %s: got %h run=%b done=%b exp=%b, expected %h run=%b done=%b exp=%b",
                     nm, got, running, done, expired, d, ru, dn, ex);
        end
    endtask

    // Expected digits for a remaining-seconds count (independent of BCD borrow logic).
    function automatic logic [15:0] secs_to_dig(input int rem);
        int m, s;
        m = rem / 60;
        s = rem % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    initial begin
        int rem;
        int exp_pulses;

        //   name          rst ld pm     ps     st pa tk  dig       run dn ex
        add("reset1",      1, 0, 7'd0,  6'd0,  0, 0, 0, 16'h0200, 0, 0, 0);
        add("reset2",      1, 0, 7'd0,  6'd0,  0, 0, 0, 16'h0200, 0, 0, 0);
        add("idle_tick1",  0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0200, 0, 0, 0);
        add("idle_tick2",  0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0200, 0, 0, 0);
        add("load_10_00",  0, 1, 7'd10, 6'd0,  0, 0, 0, 16'h1000, 0, 0, 0);
        add("start_10",    0, 0, 7'd0,  6'd0,  1, 0, 0, 16'h1000, 1, 0, 0);
        add("tick_0959",   0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0959, 1, 0, 0);
        add("load_0_10",   0, 1, 7'd0,  6'd10, 0, 0, 0, 16'h0010, 0, 0, 0);
        add("start_0010",  0, 0, 7'd0,  6'd0,  1, 0, 0, 16'h0010, 1, 0, 0);
        add("tick_0009",   0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0009, 1, 0, 0);
        add("pause_tick",  0, 0, 7'd0,  6'd0,  0, 1, 1, 16'h0009, 0, 0, 0);
        add("paused_tk1",  0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0009, 0, 0, 0);
        add("paused_tk2",  0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0009, 0, 0, 0);
        add("paused_tk3",  0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0009, 0, 0, 0);
        add("start_pause", 0, 0, 7'd0,  6'd0,  1, 1, 0, 16'h0009, 0, 0, 0);
        add("resume",      0, 0, 7'd0,  6'd0,  1, 0, 0, 16'h0009, 1, 0, 0);
        add("tick_0008",   0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0008, 1, 0, 0);
        add("load_clamp",  0, 1, 7'd120,6'd63, 1, 0, 1, 16'h9959, 0, 0, 0);
        add("start_9959",  0, 0, 7'd0,  6'd0,  1, 0, 0, 16'h9959, 1, 0, 0);
        add("tick_9958",   0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h9958, 1, 0, 0);
        add("load_in_run", 0, 1, 7'd3,  6'd0,  0, 0, 0, 16'h0300, 0, 0, 0);
        add("start_0300",  0, 0, 7'd0,  6'd0,  1, 0, 0, 16'h0300, 1, 0, 0);
        add("tick_0259",   0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0259, 1, 0, 0);
        add("reset_run",   1, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0200, 0, 0, 0);
        add("post_reset",  0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0200, 0, 0, 0);
        add("load_0000",   0, 1, 7'd0,  6'd0,  0, 0, 0, 16'h0000, 0, 0, 0);
        add("start_zero",  0, 0, 7'd0,  6'd0,  1, 0, 0, 16'h0000, 0, 0, 0);
        add("start_zero2", 0, 0, 7'd0,  6'd0,  1, 0, 1, 16'h0000, 0, 0, 0);
        add("load_0001",   0, 1, 7'd0,  6'd1,  0, 0, 0, 16'h0001, 0, 0, 0);
        add("start_0001",  0, 0, 7'd0,  6'd0,  1, 0, 0, 16'h0001, 1, 0, 0);
        add("expire",      0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0000, 0, 1, 1);
        add("done_tick",   0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0000, 0, 1, 0);
        add("done_start",  0, 0, 7'd0,  6'd0,  1, 0, 1, 16'h0000, 0, 1, 0);
        add("load_leave",  0, 1, 7'd0,  6'd59, 0, 0, 0, 16'h0059, 0, 0, 0);
        add("load_tick_ld",0, 1, 7'd1,  6'd0,  0, 0, 1, 16'h0100, 0, 0, 0);
        add("start_0100",  0, 0, 7'd0,  6'd0,  1, 0, 0, 16'h0100, 1, 0, 0);
        add("tick_0059",   0, 0, 7'd0,  6'd0,  0, 0, 1, 16'h0059, 1, 0, 0);

        drive(1, 0, 7'd0, 6'd0, 0, 0, 0);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].ld, vq[i].pm, vq[i].ps, vq[i].st, vq[i].pa, vq[i].tk);
            @(posedge clk);
            #1;
            check(vq[i].name, vq[i].dig, vq[i].run, vq[i].dn, vq[i].ex);
        end

        // Full 1:05 countdown, mixing back-to-back and spaced ticks.
        drive(0, 1, 7'd1, 6'd5, 0, 0, 0);
        @(posedge clk); #1;
        check("seq_load", 16'h0105, 0, 0, 0);
        drive(0, 0, 7'd0, 6'd0, 1, 0, 0);
        @(posedge clk); #1;
        check("seq_start", 16'h0105, 1, 0, 0);
        rem = 65;
        exp_pulses = 0;
        for (int t = 1; t <= 65; t++) begin
            drive(0, 0, 7'd0, 6'd0, 0, 0, 1);
            @(posedge clk); #1;
            rem--;
            if (expired) exp_pulses++;
            check($sformatf("seq_tick%0d", t), secs_to_dig(rem), rem != 0, rem == 0, rem == 0);
            if (t % 3 == 0) begin
                drive(0, 0, 7'd0, 6'd0, 0, 0, 0);
                @(posedge clk); #1;
                if (expired) exp_pulses++;
                check($sformatf("seq_gap%0d", t), secs_to_dig(rem), rem != 0, rem == 0, 1'b0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 7'd0, 6'd0, k[0], 0, 1);
            @(posedge clk); #1;
            if (expired) exp_pulses++;
            check($sformatf("seq_after%0d", k), 16'h0000, 0, 1, 0);
        end
        checks++;
        if (exp_pulses != 1) begin
            errors++;
            $display("FAIL seq_expired_count: got %0d pulses, expected 1", exp_pulses);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
